lights_switches_debounce: RTL
=============================

// Module: lights_switches_debounce
// PURPOSE
//   Conditions the raw DE2-115 slide-switch pins before they reach the switches
//   PIO in_port. Per bit: 2-FF synchronizer, then a saturating debounce counter.
//   Outputs are the debounced level vector and one-cycle rise/fall/change pulses.
//   Sits between the top-level SW pins and the Avalon PIO slave that reads them.
// PARAMETERS
//   WIDTH            8        number of switch bits
//   DEBOUNCE_CYCLES  500000   consecutive stable clocks required (10 ms @ 50 MHz); must be >= 1
//   CNT_W            derived  localparam $clog2(DEBOUNCE_CYCLES+1); not user-set
// PORTS
//   clk        in   1      system clock; all logic single clock domain
//   reset      in   1      asynchronous, active-high reset
//   sw_raw     in   WIDTH  asynchronous switch pins
//   sw_stable  out  WIDTH  debounced level; drives PIO in_port
//   sw_rise    out  WIDTH  1-cycle pulse per bit on debounced 0->1
//   sw_fall    out  WIDTH  1-cycle pulse per bit on debounced 1->0
//   sw_change  out  1      1-cycle pulse, OR of (sw_rise | sw_fall)
// BEHAVIOUR
//   - Reset (async assert, released on clk edge): sync regs, counters, sw_stable,
//     sw_rise, sw_fall, sw_change all 0.
//   - Sync: s1 <= sw_raw; s2 <= s1. Only s2 is used downstream; sw_raw never reaches other logic.
//   - Per bit i, on each posedge:
//       s2[i] == sw_stable[i]                  : cnt[i] <= 0 (glitch rejected)
//       mismatch, cnt[i] <  DEBOUNCE_CYCLES-1  : cnt[i] <= cnt[i]+1
//       mismatch, cnt[i] == DEBOUNCE_CYCLES-1  : sw_stable[i] <= s2[i]; cnt[i] <= 0;
//                                                rise/fall[i] <= 1 per direction
//   - Counter never exceeds DEBOUNCE_CYCLES-1. It resets, without wrapping, on any return to match.
//   - Pulses: registered, high for exactly one cycle, coincident with the sw_stable update.
//     Default 0 on every other cycle. sw_change is registered in the same cycle.
//   - Latency: edge 0 is the first clk edge sampling the new sw_raw value. The held value
//     appears on sw_stable after edge DEBOUNCE_CYCLES+1. Example: D=4 -> sw_stable changes at edge 5.
//   - Bounce: any transition restarts the count. Timing is measured from the last edge.
//   - Bits are independent. Simultaneous transitions on several bits give simultaneous
//     pulses and one sw_change pulse.
//   - A switch held high through reset: sw_stable starts 0 and rises DEBOUNCE_CYCLES+2 edges
//     after release, with a sw_rise pulse. This is intended, so software sees the initial state.
//   - Reset mid-count discards partial counts. A full period is needed after release.
// TESTING (DEBOUNCE_CYCLES=4, WIDTH=8)
//   1. reset, sw_raw=8'h00 for 20 cycles -> sw_stable=8'h00; rise/fall/change never asserted.
//   2. sw_raw 8'h00->8'h01 held -> sw_stable=8'h01 after edge 5; sw_rise=8'h01 and sw_change=1
//      for exactly 1 cycle.
//   3. sw_raw[3] high for 3 cycles, then low -> sw_stable unchanged; no pulses.
//   4. sw_raw[2] toggles every 2 cycles x5, then holds 1 -> single sw_rise[2];
//      sw_stable[2]=1 at edge 5 counted from the last transition.
//   5. stable 8'h80, sw_raw->8'h01 in one cycle -> same cycle: sw_rise=8'h01, sw_fall=8'h80,
//      one sw_change pulse, sw_stable=8'h01.
//   6. sw_raw[0]=1, assert reset at count 2 for 3 cycles -> outputs 0 immediately;
//      sw_stable[0]=1 after edge 5 counted from the first post-release edge.

Source files
------------

// File: rtl/lights_switches_debounce_if.sv
// Switch-conditioning bus: raw pins in, debounced level and edge pulses out.
// The debouncer takes the slave side; whoever drives the pins and reads the results takes the master side.
interface lights_switches_debounce_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_stable;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_change;

  modport master (
    output sw_raw,
    input  sw_stable,
    input  sw_rise,
    input  sw_fall,
    input  sw_change
  );

  modport slave (
    input  sw_raw,
    output sw_stable,
    output sw_rise,
    output sw_fall,
    output sw_change
  );
endinterface

// File: rtl/lights_switches_debounce.sv
// Slide-switch conditioner: per-bit 2-FF synchronizer followed by a saturating
// debounce counter, producing a debounced level plus one-cycle rise/fall/change pulses.
module lights_switches_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                       clk,
  input  logic                       reset,
  lights_switches_debounce_if.slave  sw_bus
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] s1_reg;
  logic [WIDTH-1:0] s2_reg;
  logic [WIDTH-1:0] stable_reg;
  logic [WIDTH-1:0] stable_next;
  logic [WIDTH-1:0] rise_reg;
  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] fall_reg;
  logic [WIDTH-1:0] fall_next;
  logic             change_reg;
  logic             change_next;

  // Only s2_reg feeds the debounce logic; sw_raw stops at the first flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= sw_bus.sw_raw;
      s2_reg <= s1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             bit_stable_next;
      logic             bit_rise_next;
      logic             bit_fall_next;

      always_comb begin
        cnt_next        = cnt_reg;
        bit_stable_next = stable_reg[gi];
        bit_rise_next   = 1'b0;
        bit_fall_next   = 1'b0;
        if (s2_reg[gi] == stable_reg[gi]) begin
          cnt_next = '0;
        end else if (cnt_reg == CNT_MAX) begin
          // This mismatching sample completes the run of DEBOUNCE_CYCLES.
          cnt_next        = '0;
          bit_stable_next = s2_reg[gi];
          bit_rise_next   = s2_reg[gi];
          bit_fall_next   = ~s2_reg[gi];
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign stable_next[gi] = bit_stable_next;
      assign rise_next[gi]   = bit_rise_next;
      assign fall_next[gi]   = bit_fall_next;
    end
  endgenerate

  assign change_next = |(rise_next | fall_next);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_reg <= '0;
      rise_reg   <= '0;
      fall_reg   <= '0;
      change_reg <= 1'b0;
    end else begin
      stable_reg <= stable_next;
      rise_reg   <= rise_next;
      fall_reg   <= fall_next;
      change_reg <= change_next;
    end
  end

  assign sw_bus.sw_stable = stable_reg;
  assign sw_bus.sw_rise   = rise_reg;
  assign sw_bus.sw_fall   = fall_reg;
  assign sw_bus.sw_change = change_reg;

endmodule
